// File: rtl/ring_scan_decoder.sv
// ring_scan_decoder: one-hot anode ring scan with skip mask,
// anti-ghost blanking, PWM brightness and selectable polarity.
module ring_scan_decoder #(
  parameter int N_DIGITS         = 4,
  parameter int PRESCALE_LOG2    = 4,
  parameter int BLANK_CYCLES     = 2,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int SEL_W = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Enable,
  input  logic [N_DIGITS-1:0] i_DigitMask,
  input  logic [3:0]          i_Bright,
  output logic [SEL_W-1:0]    o_Sel,
  output logic [N_DIGITS-1:0] o_Anodos,
  output logic                o_SlotStart
);

  localparam logic [PRESCALE_LOG2-1:0] LP_CMAX  = '1;
  localparam logic [PRESCALE_LOG2-1:0] LP_BLANK =
    PRESCALE_LOG2'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] LP_SMAX = SEL_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] LP_IDLE =
    {N_DIGITS{ANODE_ACTIVE_LOW}};

  logic [PRESCALE_LOG2-1:0] r_cnt;
  logic [SEL_W-1:0]         r_sel;
  logic [N_DIGITS-1:0]      r_an;
  logic                     r_ss;

  logic                     w_wrap;
  logic [PRESCALE_LOG2-1:0] w_cnt_nxt;
  logic [SEL_W-1:0]         w_plain;
  logic [SEL_W-1:0]         w_hunt;
  logic                     w_found;
  logic [SEL_W:0]           w_try;
  logic [SEL_W-1:0]         w_idx;
  logic [SEL_W-1:0]         w_sel_nxt;
  logic                     w_on;
  logic [N_DIGITS-1:0]      w_an;
  logic [N_DIGITS-1:0]      w_drive;

  assign w_wrap    = (r_cnt == LP_CMAX);
  assign w_cnt_nxt = r_cnt + PRESCALE_LOG2'(1);
  assign w_plain   = (r_sel == LP_SMAX) ? '0 : r_sel + SEL_W'(1);

  // First enabled index above sel, wrapping; k=N lands back on sel.
  always_comb begin
    w_hunt  = w_plain;
    w_found = 1'b0;
    w_try   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_DIGITS; k++) begin
      w_try = {1'b0, r_sel} + (SEL_W+1)'(k);
      if (w_try >= (SEL_W+1)'(N_DIGITS))
        w_try = w_try - (SEL_W+1)'(N_DIGITS);
      w_idx = w_try[SEL_W-1:0];
      if (!w_found && i_DigitMask[w_idx]) begin
        w_found = 1'b1;
        w_hunt  = w_idx;
      end
    end
  end

  assign w_sel_nxt = w_wrap ? w_hunt : r_sel;

  // Decode from next-state so sel and anodes switch together.
  assign w_on = i_Enable
             && i_DigitMask[w_sel_nxt]
             && (w_cnt_nxt >= LP_BLANK)
             && (w_cnt_nxt[PRESCALE_LOG2-1 -: 4] <= i_Bright);

  always_comb begin
    w_an = '0;
    for (int k = 0; k < N_DIGITS; k++)
      w_an[k] = w_on && (w_sel_nxt == SEL_W'(k));
  end

  assign w_drive = ANODE_ACTIVE_LOW ? ~w_an : w_an;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_cnt <= '0;
      r_sel <= '0;
      r_an  <= LP_IDLE;
      r_ss  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sel <= w_sel_nxt;
      r_an  <= w_drive;
      r_ss  <= w_wrap;
    end
  end

  assign o_Sel       = r_sel;
  assign o_Anodos    = r_an;
  assign o_SlotStart = r_ss;

endmodule

// File: tb/tb_ring_scan_decoder.sv
// Scoreboard bench for ring_scan_decoder: active-low and
// active-high instances driven in lockstep against a slot model.
module tb_ring_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] mask = 4'h0;
  logic [3:0] bright = 4'h0;

  logic [1:0] sel_l, sel_h;
  logic [3:0] an_l, an_h;
  logic       ss_l, ss_h;

  int errors = 0;
  int checks = 0;
  int m_cnt = 0;
  int m_sel = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] anl;
    logic       ss;
    logic [1:0] selh;
    logic [3:0] anh;
    logic       ssh;
  } obs_t;

  obs_t q_exp[$];
  obs_t q_act[$];

  ring_scan_decoder #(
    .N_DIGITS(4), .PRESCALE_LOG2(4),
    .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1'b1)
  ) u_dut_l (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
    .i_DigitMask(mask), .i_Bright(bright),
    .o_Sel(sel_l), .o_Anodos(an_l), .o_SlotStart(ss_l)
  );

  ring_scan_decoder #(
    .N_DIGITS(4), .PRESCALE_LOG2(4),
    .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1'b0)
  ) u_dut_h (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
    .i_DigitMask(mask), .i_Bright(bright),
    .o_Sel(sel_h), .o_Anodos(an_h), .o_SlotStart(ss_h)
  );

  always #5 clk = ~clk;

  // Predict next outputs from current inputs, then clock once.
  task automatic tick();
    obs_t e, a;
    int nc, ns;
    logic on, ss;
    logic [3:0] oh;
    if (rst) begin
      m_cnt = 0; m_sel = 0; on = 1'b0; ss = 1'b0;
    end else begin
      ss = (m_cnt == 15);
      nc = (m_cnt + 1) % 16;
      ns = m_sel;
      if (m_cnt == 15) begin
        ns = (m_sel + 1) % 4;
        for (int k = 4; k >= 1; k--)
          if (mask[(m_sel + k) % 4]) ns = (m_sel + k) % 4;
      end
      on = en && mask[ns] && (nc >= 2) && (nc <= int'(bright));
      m_cnt = nc;
      m_sel = ns;
    end
    oh = on ? 4'(1 << m_sel) : 4'h0;
    e.sel = 2'(m_sel); e.anl = ~oh; e.ss = ss;
    e.selh = 2'(m_sel); e.anh = oh; e.ssh = ss;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    a.sel = sel_l; a.anl = an_l; a.ss = ss_l;
    a.selh = sel_h; a.anh = an_h; a.ssh = ss_h;
    q_act.push_back(a);
  endtask

  task automatic test_reset();
    obs_t e, a;
    rst = 1'b1; en = 1'b1; mask = 4'hF; bright = 4'hF;
    repeat (3) tick();
    checks++;
    if ({sel_l, an_l, ss_l, an_h} !== {2'd0, 4'hF, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state got=%b_%b_%b_%b exp=00_1111_0_0000",
               sel_l, an_l, ss_l, an_h);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL reset_sb got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_full_scan();
    obs_t e, a;
    int ph, s;
    logic [3:0] oh;
    rst = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      ph = i % 16; s = (i / 16) % 4;
      oh = (ph >= 2) ? 4'(1 << s) : 4'h0;
      checks++;
      if ({ss_l, sel_l, an_l, an_h} !== {ph == 0, 2'(s), ~oh, oh}) begin
        errors++;
        $display("FAIL full_scan i=%0d got=%b_%0d_%b_%b exp=%b_%0d_%b_%b",
                 i, ss_l, sel_l, an_l, an_h, ph == 0, s, ~oh, oh);
      end
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL full_scan_sb got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_bright();
    obs_t e, a;
    int act;
    logic [3:0] want;
    bright = 4'd7; act = 0;
    repeat (32) begin
      tick();
      want = (m_cnt >= 2 && m_cnt <= 7) ? ~4'(1 << m_sel) : 4'hF;
      if (an_l != 4'hF) act++;
      checks++;
      if (an_l !== want) begin
        errors++;
        $display("FAIL bright7 cnt=%0d got=%b exp=%b", m_cnt, an_l, want);
      end
    end
    checks++;
    if (act !== 12) begin
      errors++; $display("FAIL bright7_width got=%0d exp=12", act);
    end
    bright = 4'd1;
    repeat (16) begin
      tick();
      checks++;
      if (an_l !== 4'hF) begin
        errors++; $display("FAIL bright1 got=%b exp=1111", an_l);
      end
    end
    bright = 4'hF;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL bright_sb got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_mask();
    obs_t e, a;
    int nss, prev, n;
    mask = 4'b0101; nss = 0; prev = -1;
    repeat (64) begin
      tick();
      if (ss_l) begin
        nss++;
        checks++;
        if (!((sel_l == 2'd0 || sel_l == 2'd2) && int'(sel_l) != prev)) begin
          errors++;
          $display("FAIL mask0101_seq got=%0d prev=%0d exp=0/2 alt",
                   sel_l, prev);
        end
        prev = int'(sel_l);
      end
    end
    checks++;
    if (nss !== 4) begin
      errors++; $display("FAIL mask0101_slots got=%0d exp=4", nss);
    end
    repeat (5) tick();
    mask = 4'b1000; n = 0;
    do begin tick(); n++; end while (!ss_l && n < 20);
    checks++;
    if (!ss_l || sel_l !== 2'd3 || n !== 11) begin
      errors++;
      $display("FAIL mask_midslot got=sel%0d n=%0d exp=sel3 n=11", sel_l, n);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL mask_sb got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_zero_mask();
    obs_t e, a;
    int nss, prev;
    mask = 4'b0000; nss = 0; prev = 3;
    repeat (64) begin
      tick();
      checks++;
      if (an_l !== 4'hF || an_h !== 4'h0) begin
        errors++;
        $display("FAIL zero_mask_an got=%b/%b exp=1111/0000", an_l, an_h);
      end
      if (ss_l) begin
        nss++;
        checks++;
        if (int'(sel_l) != (prev + 1) % 4) begin
          errors++;
          $display("FAIL zero_mask_seq got=%0d exp=%0d", sel_l, (prev + 1) % 4);
        end
        prev = int'(sel_l);
      end
    end
    checks++;
    if (nss !== 4) begin
      errors++; $display("FAIL zero_mask_slots got=%0d exp=4", nss);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL zero_mask_sb got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, a;
    int n;
    mask = 4'hF; n = 0;
    do begin tick(); n++; end while (!(sel_l == 2'd2 && m_cnt == 9) && n < 200);
    checks++;
    if (!(sel_l == 2'd2 && m_cnt == 9)) begin
      errors++; $display("FAIL reset_mid_reach got=sel%0d exp=sel2", sel_l);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({sel_l, an_l, ss_l, an_h} !== {2'd0, 4'hF, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_mid got=%0d_%b_%b exp=0_1111_0", sel_l, an_l, ss_l);
    end
    n = 0;
    do begin tick(); n++; end while (!ss_l && n < 40);
    checks++;
    if (!ss_l || n !== 16 || sel_l !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid_slot got=n%0d sel%0d exp=n16 sel1", n, sel_l);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL reset_mid_sb got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_enable();
    obs_t e, a;
    int nss;
    repeat (5) tick();
    checks++;
    if (an_l === 4'hF) begin
      errors++; $display("FAIL enable_pre got=%b exp=active", an_l);
    end
    en = 1'b0; nss = 0;
    repeat (40) begin
      tick();
      if (ss_l) nss++;
      checks++;
      if (an_l !== 4'hF || an_h !== 4'h0) begin
        errors++;
        $display("FAIL enable_off got=%b/%b exp=1111/0000", an_l, an_h);
      end
    end
    checks++;
    if (nss !== 2) begin
      errors++; $display("FAIL enable_scan got=%0d exp=2", nss);
    end
    en = 1'b1;
    repeat (4) tick();
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL enable_sb got=%h exp=%h", a, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_scan();
    test_bright();
    test_mask();
    test_zero_mask();
    test_reset_mid();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
